// File: rtl/mem_responder_pkg.sv
// mem_responder shared encodings: access sizes, error codes, FSM states.
package mem_responder_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/mem_resp_align.sv
// Size/alignment check and big-endian byte-lane mux for mem_responder.
// MEM_RESPONDER_BOUNDS_CHECK_EN enables the out-of-range error.
module mem_resp_align
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        write,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] rbytes,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wbytes,
    output logic [1:0]  err_code
);

    logic [31:0] rd;
    logic [3:0]  lane_be;

`ifndef MEM_RESPONDER_BOUNDS_CHECK_EN
    logic unused_hi;
    assign unused_hi = ^addr[31:ADDR_W];
`endif

    always_comb begin
        err_code = ERR_NONE;
        if (size == SZ_RSVD) begin
            err_code = ERR_SIZE;
        end else if ((size == SZ_HALF && addr[0]) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00)) begin
            err_code = ERR_MISALIGN;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        end else if (addr[31:ADDR_W] != '0) begin
            err_code = ERR_RANGE;
`endif
        end
    end

    // rbytes[31:24] is m[A]; lane bit 3 addresses m[A]
    always_comb begin
        rd      = '0;
        lane_be = '0;
        wbytes  = '0;
        unique case (size)
            SZ_WORD: begin
                rd      = rbytes;
                lane_be = 4'b1111;
                wbytes  = wdata;
            end
            SZ_HALF: begin
                rd      = {16'h0, rbytes[31:16]};
                lane_be = 4'b1100;
                wbytes  = {wdata[15:0], 16'h0};
            end
            SZ_BYTE: begin
                rd      = {24'h0, rbytes[31:24]};
                lane_be = 4'b1000;
                wbytes  = {wdata[7:0], 24'h0};
            end
            default: ;
        endcase
    end

    assign rdata = (write || err_code != ERR_NONE) ? 32'h0 : rd;
    assign be    = (write && err_code == ERR_NONE) ? lane_be : 4'b0;

endmodule

// File: rtl/mem_responder.sv
// Wait-stated big-endian memory responder with one outstanding request.
// Optional MEM_RESPONDER_BOUNDS_CHECK_EN flags addresses beyond the array.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  rsp_err_code
);

    logic [7:0]        mem [2**ADDR_W];
    state_t            state;
    logic [2:0]        cnt;
    logic              wr;
    logic [1:0]        sz;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] idx [4];
    logic [31:0]       rbytes;
    logic [31:0]       rdata;
    logic [31:0]       wbytes;
    logic [3:0]        be;
    logic [1:0]        err_code;
    logic              access;

    assign access = (state == ST_BUSY) && (cnt == 3'd0);

    // byte indices wrap modulo the array size
    always_comb begin
        rbytes = '0;
        for (int k = 0; k < 4; k++) begin
            idx[k] = addr[ADDR_W-1:0] + ADDR_W'(k);
            rbytes[31-8*k -: 8] = mem[idx[k]];
        end
    end

    mem_resp_align #(
        .ADDR_W(ADDR_W)
    ) u_align (
        .write   (wr),
        .size    (sz),
        .addr    (addr),
        .rbytes  (rbytes),
        .wdata   (wdata),
        .rdata   (rdata),
        .be      (be),
        .wbytes  (wbytes),
        .err_code(err_code)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= 3'd0;
            wr           <= 1'b0;
            sz           <= SZ_WORD;
            addr         <= '0;
            wdata        <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            rsp_err_code <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        wr        <= req_write;
                        sz        <= req_size;
                        addr      <= req_addr;
                        wdata     <= req_wdata;
                        cnt       <= 3'(LATENCY);
                        req_ready <= 1'b0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= rdata;
                        rsp_err      <= (err_code != ERR_NONE);
                        rsp_err_code <= err_code;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // array is not reset; an async reset in BUSY leaves access low
    always_ff @(posedge clk) begin
        if (access) begin
            for (int k = 0; k < 4; k++) begin
                if (be[3-k]) mem[idx[k]] <= wbytes[31-8*k -: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_err_code;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W (8),
        .LATENCY(LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_err_code(rsp_err_code)
    );

    // entered and left 1 time unit after a rising edge
    task automatic xact(input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e,
                        output logic [1:0] c, output int lat,
                        output logic rdy_after);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL req_ready_timeout addr=%h", a);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) begin
            vectors++; miscompares++;
            $display("FAIL rsp_valid_timeout addr=%h", a);
        end
        rd = rsp_rdata;
        e  = rsp_err;
        c  = rsp_err_code;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        rdy_after = req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, rsp_err_code} !== 5'b0 ||
            rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy=%b v=%b d=%h e=%b c=%b want all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_edge got %b want 1", req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; logic [1:0] c; int lat; logic ra;
        xact(1'b1, 2'b00, 32'h10, 32'h11223344, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b0 || rd !== 32'h0 || lat != LAT + 2) begin
            miscompares++;
            $display("FAIL store_word got e=%b d=%h lat=%0d want 0 0 %0d",
                     e, rd, lat, LAT + 2);
        end
        xact(1'b0, 2'b00, 32'h10, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b0 || rd !== 32'h11223344) begin
            miscompares++;
            $display("FAIL load_word got e=%b d=%h want 0 11223344", e, rd);
        end
        vectors++;
        if (lat != LAT + 2 || ra !== 1'b1) begin
            miscompares++;
            $display("FAIL load_timing got lat=%0d rdy=%b want %0d 1",
                     lat, ra, LAT + 2);
        end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic e; logic [1:0] c; int lat; logic ra;
        xact(1'b0, 2'b10, 32'h11, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b0 || rd !== 32'h00000022) begin
            miscompares++;
            $display("FAIL load_byte got e=%b d=%h want 0 00000022", e, rd);
        end
        xact(1'b0, 2'b01, 32'h12, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b0 || rd !== 32'h00003344) begin
            miscompares++;
            $display("FAIL load_half got e=%b d=%h want 0 00003344", e, rd);
        end
        xact(1'b1, 2'b10, 32'h13, 32'hFFFFFFAB, rd, e, c, lat, ra);
        xact(1'b0, 2'b00, 32'h10, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b0 || rd !== 32'h112233AB) begin
            miscompares++;
            $display("FAIL store_byte got d=%h want 112233AB", rd);
        end
        xact(1'b1, 2'b01, 32'h14, 32'hFFFFBEEF, rd, e, c, lat, ra);
        xact(1'b0, 2'b00, 32'h14, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (rd[31:16] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL store_half got d=%h want BEEFxxxx", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; logic [1:0] c; int lat; logic ra;
        xact(1'b1, 2'b00, 32'h20, 32'hCAFEF00D, rd, e, c, lat, ra);
        xact(1'b0, 2'b01, 32'h21, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b1 || c !== 2'b01 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL half_misalign got e=%b c=%b d=%h want 1 01 0",
                     e, c, rd);
        end
        xact(1'b1, 2'b00, 32'h22, 32'hFFFFFFFF, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b1 || c !== 2'b01) begin
            miscompares++;
            $display("FAIL word_misalign got e=%b c=%b want 1 01", e, c);
        end
        xact(1'b0, 2'b00, 32'h20, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b0 || rd !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL misalign_nowrite got d=%h want CAFEF00D", rd);
        end
        xact(1'b0, 2'b11, 32'h11, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (e !== 1'b1 || c !== 2'b11 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL bad_size got e=%b c=%b d=%h want 1 11 0", e, c, rd);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] rd; logic e; logic [1:0] c; int lat; logic ra;
        xact(1'b1, 2'b00, 32'h00, 32'h01020304, rd, e, c, lat, ra);
        xact(1'b0, 2'b00, 32'h100, 32'h0, rd, e, c, lat, ra);
        vectors++;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        if (e !== 1'b1 || c !== 2'b10 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL out_of_range got e=%b c=%b d=%h want 1 10 0",
                     e, c, rd);
        end
`else
        if (e !== 1'b0 || c !== 2'b00 || rd !== 32'h01020304) begin
            miscompares++;
            $display("FAIL addr_wrap got e=%b c=%b d=%h want 0 00 01020304",
                     e, c, rd);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic e; logic [1:0] c; int lat; logic ra;
        int n;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        @(posedge clk); #1;
        req_write = 1'b1;
        req_wdata = 32'hFFFFFFFF;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h112233AB ||
                req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h rdy=%b want 1 112233AB 0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release got v=%b rdy=%b want 0 1",
                     rsp_valid, req_ready);
        end
        xact(1'b0, 2'b00, 32'h10, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (rd !== 32'h112233AB) begin
            miscompares++;
            $display("FAIL stall_ignored_req got d=%h want 112233AB", rd);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd; logic e; logic [1:0] c; int lat; logic ra;
        xact(1'b1, 2'b00, 32'h30, 32'h55667788, rd, e, c, lat, ra);
        xact(1'b0, 2'b00, 32'h30, 32'h0, rd, e, c, lat, ra);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h30;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, rsp_err_code} !== 5'b0 ||
            rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL busy_reset got rdy=%b v=%b d=%h e=%b c=%b want all 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        xact(1'b0, 2'b00, 32'h30, 32'h0, rd, e, c, lat, ra);
        vectors++;
        if (rd !== 32'h55667788) begin
            miscompares++;
            $display("FAIL store_aborted got d=%h want 55667788", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_bounds();
        test_stall();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
